// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the TDC pair-difference measurement path.
package tdc_pkg;

    localparam int TDC_DW   = 37;
    localparam int TDC_TMO  = 4095;
    localparam int TDC_SEQW = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_A  = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_REQ_B  = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_EMIT   = 3'd5
    } sched_st_t;

    // The wait counter only has to reach TMO-1 before the timeout fires.
    function automatic int tmo_cnt_width(input int tmo);
        return (tmo < 3) ? 1 : $clog2(tmo);
    endfunction

endpackage

// File: rtl/tdc_tick_sync.sv
// Three-flop synchronizer for a slow strobe from another clock domain,
// producing a one-cycle pulse on each synchronized rising edge.
module tdc_tick_sync
    import tdc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe_i,
    output logic pulse_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= strobe_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/tdc_pair_sched.sv
// Measurement scheduler: per strobe tick, requests a reference then a sample
// conversion and emits both results as one tagged pair.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a tick while enabled
//   REQ_A   | reference request issued, wait counter cleared
//   WAIT_A  | waiting for the reference result (bounded by TMO)
//   REQ_B   | sample request issued, wait counter cleared
//   WAIT_B  | waiting for the sample result (bounded by TMO)
//   EMIT    | pair presented downstream, tag advances
module tdc_pair_sched
    import tdc_pkg::*;
#(
    parameter int DW   = TDC_DW,
    parameter int TMO  = TDC_TMO,
    parameter int SEQW = TDC_SEQW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_10k,
    input  logic            en,
    input  logic            dval,
    input  logic [DW-1:0]   mlt,
    output logic            meas_req,
    output logic            meas_sel,
    output logic            pair_dval,
    output logic [DW-1:0]   ref_data,
    output logic [DW-1:0]   smp_data,
    output logic [SEQW-1:0] seq,
    output logic            tmo_err,
    output logic [SEQW-1:0] ovr_cnt,
    output logic            busy
);

    localparam int              TW       = tmo_cnt_width(TMO);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TMO - 1);
    localparam logic [SEQW-1:0] OVR_MAX  = '1;

    logic            tick_p;
    sched_st_t       state_q;
    logic [TW-1:0]   tmo_q;
    logic [DW-1:0]   a_q;
    logic [SEQW-1:0] seq_cnt_q;
    logic            meas_req_q;
    logic            meas_sel_q;
    logic            pair_dval_q;
    logic [DW-1:0]   ref_data_q;
    logic [DW-1:0]   smp_data_q;
    logic [SEQW-1:0] seq_q;
    logic            tmo_err_q;
    logic [SEQW-1:0] ovr_cnt_q;
    logic            busy_q;

    tdc_tick_sync u_tick (
        .clk      (clk),
        .rst      (rst),
        .strobe_i (clk_10k),
        .pulse_o  (tick_p)
    );

    // Outputs are set on the transition into a state so they are visible
    // during that state, which keeps the tick-to-pair latency at 5 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            a_q         <= '0;
            seq_cnt_q   <= '0;
            meas_req_q  <= 1'b0;
            meas_sel_q  <= 1'b0;
            pair_dval_q <= 1'b0;
            ref_data_q  <= '0;
            smp_data_q  <= '0;
            seq_q       <= '0;
            tmo_err_q   <= 1'b0;
            ovr_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            meas_req_q  <= 1'b0;
            pair_dval_q <= 1'b0;
            tmo_err_q   <= 1'b0;

            if (tick_p && (state_q != ST_IDLE) && (ovr_cnt_q != OVR_MAX)) begin
                ovr_cnt_q <= ovr_cnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick_p && en) begin
                        state_q    <= ST_REQ_A;
                        meas_req_q <= 1'b1;
                        meas_sel_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                ST_REQ_A: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT_A;
                end

                ST_WAIT_A: begin
                    if (dval) begin
                        a_q        <= mlt;
                        state_q    <= ST_REQ_B;
                        meas_req_q <= 1'b1;
                        meas_sel_q <= 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q   <= ST_IDLE;
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                ST_REQ_B: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT_B;
                end

                ST_WAIT_B: begin
                    if (dval) begin
                        ref_data_q  <= a_q;
                        smp_data_q  <= mlt;
                        seq_q       <= seq_cnt_q;
                        pair_dval_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else if (tmo_q == TMO_LAST) begin
                        a_q       <= '0;
                        state_q   <= ST_IDLE;
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                ST_EMIT: begin
                    seq_cnt_q <= seq_cnt_q + 1'b1;
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign meas_req  = meas_req_q;
    assign meas_sel  = meas_sel_q;
    assign pair_dval = pair_dval_q;
    assign ref_data  = ref_data_q;
    assign smp_data  = smp_data_q;
    assign seq       = seq_q;
    assign tmo_err   = tmo_err_q;
    assign ovr_cnt   = ovr_cnt_q;
    assign busy      = busy_q;

endmodule

// File: doc/tdc_pair_sched.md
# tdc_pair_sched

Measurement scheduler for the TDC pair-difference path. On every rising edge of the slow `clk_10k` strobe it requests a reference conversion, then a sample conversion, from the TDC/multiplier front end. It captures both `mlt` results and presents them as one tagged pair to the downstream difference stage. Lost conversions are handled with a timeout, and ticks arriving while a pair is in flight are counted as overruns.

## Interface
- `DW`, 37: width of front-end result `mlt`.
- `TMO`, 4095: max `clk` cycles spent in a wait state without `dval`.
- `SEQW`, 8: width of pair sequence tag and overrun counter.

- `clk`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `clk_10k`, in, 1: 10 kHz measurement strobe from another domain; synchronized internally.
- `en`, in, 1: scheduler enable, sampled in IDLE only.
- `dval`, in, 1: front-end result valid, 1-cycle pulse.
- `mlt`, in, DW: front-end result, valid when `dval`=1.
- `meas_req`, out, 1: conversion request pulse to the front end.
- `meas_sel`, out, 1: 0 = reference channel, 1 = sample channel; valid with `meas_req`, held until the next request.
- `pair_dval`, out, 1: 1-cycle pulse when `ref_data`/`smp_data`/`seq` are updated.
- `ref_data`, out, DW: reference result of the last complete pair.
- `smp_data`, out, DW: sample result of the last complete pair.
- `seq`, out, SEQW: tag of the last complete pair.
- `tmo_err`, out, 1: 1-cycle pulse when a wait state times out.
- `ovr_cnt`, out, SEQW: saturating count of ticks dropped while busy.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Tick detect: 3-flop chain `s1`←`clk_10k`, `s2`←`s1`, `s3`←`s2`; `tick_p = s2 & ~s3`.
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, EMIT.
- IDLE: on `tick_p & en` go to REQ_A; otherwise stay.
- REQ_A: `meas_req`=1, `meas_sel`=0, clear the timeout counter, go to WAIT_A.
- WAIT_A:
  - on `dval`, latch `mlt` into internal `a_reg` and go to REQ_B;
  - else increment the timeout counter;
  - on the TMO-th consecutive cycle without `dval`, go to IDLE and pulse `tmo_err`.
- REQ_B: `meas_req`=1, `meas_sel`=1, clear the timeout counter, go to WAIT_B.
- WAIT_B: same rules as WAIT_A, latching into `b_reg`. On timeout, `a_reg` is discarded.
- EMIT:
  - `ref_data`←`a_reg`, `smp_data`←`b_reg`, `pair_dval`=1;
  - `seq` increments after emit, so the first pair carries `seq`=0;
  - go to IDLE.
- `seq` wraps from 2^SEQW−1 to 0. It does not advance on timeout.
- `tick_p` in any state other than IDLE: the tick is dropped and `ovr_cnt` increments, saturating at 2^SEQW−1.
- `tick_p` in IDLE with `en`=0: ignored and not counted.
- `dval` in IDLE, REQ_A, REQ_B or EMIT: ignored.
- `dval` on the same cycle the timeout would fire: `dval` wins and the data is captured.
- `en` deasserted mid-pair: the pair completes; the block then stays in IDLE.
- No arithmetic on data; results pass through at full DW width.

## Timing
- Reset values:
  - state IDLE, sync flops 0, timeout counter 0;
  - `meas_req`=0, `meas_sel`=0, `pair_dval`=0, `tmo_err`=0, `busy`=0;
  - `ref_data`=0, `smp_data`=0, `seq`=0, `ovr_cnt`=0.
- Reset asserted mid-pair: all of the above apply immediately; no partial pair is emitted.
- `tick_p` rises on the 2nd `clk` edge after the first edge that samples `clk_10k`=1.
- Latency, with `tick_p` at cycle T:
  - REQ_A (`meas_req`) at T+1;
  - `dval` is accepted from T+2; with reference `dval` at T+2+a, REQ_B is at T+3+a;
  - with sample `dval` at T+4+a+b, `pair_dval` is at T+5+a+b;
  - minimum tick-to-`pair_dval` latency is 5 cycles.
- Timeout: with no `dval`, `tmo_err` and return to IDLE occur TMO+1 cycles after REQ_x.
- All outputs are registered; none is combinational from inputs.

## Structure
- Shared package `tdc_pkg`:
  - state enum `sched_st_t`;
  - default constants `TDC_DW`=37, `TDC_TMO`=4095, `TDC_SEQW`=8.
- One sub-module, `tdc_tick_sync`: 3-flop synchronizer plus rising-edge pulse. It has `clk`/`rst`, and is reused for other slow strobes.
- The FSM, timeout counter and capture registers stay in `tdc_pair_sched`.

## Test plan
- Nominal pair:
  - stimulus: `en`=1, one `clk_10k` edge; `dval` 3 cycles after each `meas_req`; `mlt`=0x0_0001_2345 then 0x0_0001_2400;
  - response: two `meas_req` pulses (`meas_sel` 0 then 1), one `pair_dval` with matching `ref_data`/`smp_data`, `seq`=0.
- Minimum latency:
  - stimulus: `dval` on the first cycle after each REQ;
  - response: `pair_dval` exactly 5 cycles after `tick_p`.
- Timeout with TMO=16:
  - stimulus: no reference `dval`;
  - response: `tmo_err` 17 cycles after REQ_A, no `pair_dval`, `seq` unchanged, next tick restarts normally.
- Overrun:
  - stimulus: 3 ticks while in WAIT_B;
  - response: `ovr_cnt`=3, only one pair emitted; 300 ticks while busy saturates `ovr_cnt` at 255.
- Boundaries:
  - `dval` coincident with the timeout cycle → captured, no `tmo_err`;
  - 256 pairs → `seq` wraps to 0;
  - `en`=0 in WAIT_A → pair still completes.
- Reset in WAIT_B: all outputs return to reset values at once, and no `pair_dval` appears afterward.
